icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Direct-mapped instruction cache + miss/refill FSM for the dual-issue fetch stage.
//  Serves an aligned 64-bit instruction pair per cycle on a hit; on a miss drives imem_miss
//  (consumed by stall_flush_control as PC_stall) and refills one line from backing memory.
//  Sits between IF stage and the instruction memory port.
// PARAMETERS
//  LINES       16  number of cache lines (power of 2, >=2)
//  LINE_WORDS  4   32-bit words per line (power of 2, >=2); line = LINE_WORDS*4 bytes
//  ADDR_W      32  byte-address width
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset_n     in   1       asynchronous active-low reset
//  fetch_req   in   1       IF requests an instruction pair this cycle
//  fetch_addr  in   ADDR_W  byte address of pair; bits[2:0]==0 required
//  fetch_data  out  64      {instr@addr+4, instr@addr}
//  fetch_valid out  1       fetch_data valid (hit) this cycle
//  imem_miss   out  1       miss pending; IF must hold fetch_addr stable while high
//  inv_all     in   1       fence.i: invalidate entire cache
//  mem_req     out  1       line-read request to memory
//  mem_addr    out  ADDR_W  line base address (low log2(LINE_WORDS*4) bits zero)
//  mem_ready   in   1       memory accepts request (handshake with mem_req)
//  mem_rvalid  in   1       one refill beat valid
//  mem_rdata   in   32      refill beat, ascending word order from line base
// BEHAVIOUR
//  Reset: state IDLE, all valid bits 0, beat counter 0; fetch_valid=0, imem_miss=0,
//   mem_req=0, mem_addr=0. Data/tag arrays not reset.
//  Address split: offset=[log2(LINE_WORDS*4)-1:0], index=next log2(LINES) bits, tag=rest.
//   Pairs are 8B-aligned so never cross a line.
//  Lookup combinational: hit = fetch_req & valid[idx] & tag[idx]==addr tag.
//  IDLE: hit -> fetch_valid=1, fetch_data same cycle, imem_miss=0.
//   fetch_req & !hit -> imem_miss=1 this cycle, latch line address, go REQ.
//   fetch_req=0 -> fetch_valid=0, imem_miss=0.
//  REQ: mem_req=1, mem_addr=latched line base, imem_miss=1; mem_req/mem_addr held until
//   mem_ready=1 sampled high; then REFILL. Exactly one request per miss.
//  REFILL: imem_miss=1, mem_req=0; each mem_rvalid writes mem_rdata to word[beat], beat++.
//   On beat LINE_WORDS-1: write tag, set valid (unless inv_pend), beat<=0, go IDLE.
//   Beats with mem_rvalid=0 ignored; mem_rvalid outside REFILL ignored.
//  Miss-to-hit latency: 1 (IDLE) + REQ cycles to mem_ready + beat cycles + 1 (IDLE hit).
//  fetch_valid never asserted outside IDLE; fetch_valid and imem_miss never both high.
//  inv_all: clears all valid bits at next edge. IDLE same-cycle hit still served (old
//   valid). During REQ/REFILL: sets inv_pend; refill completes (beats consumed) but the
//   line is NOT marked valid; inv_pend cleared on return to IDLE -> re-miss, re-fetch.
//  fetch_addr change while imem_miss=1 is a protocol violation (assertion), not handled.
//  Reset mid-refill: immediate return to IDLE, all lines invalid; memory side shares
//   reset_n so no stale beats arrive afterwards.
//  Index wrap: last line (idx=LINES-1) and first line handled identically; no aliasing
//   besides tag conflicts (refill overwrites the conflicting line).
// CONFIGURATION
//  ICACHE_MISS_CNT_EN defined: adds output miss_count [31:0], reset 0, +1 on each
//   IDLE->REQ transition, saturates at 32'hFFFF_FFFF, cleared by inv_all.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  Cold miss: reset, fetch 0x100 -> imem_miss=1, mem_req with mem_addr=0x100; ready next
//   cycle, 4 beats 0xA0..0xA3 -> next cycle fetch_valid=1, fetch_data=0x000000A1_000000A0.
//  Hit: then fetch 0x108 -> same-cycle fetch_valid=1, data {0xA3,0xA2}, no mem_req.
//  Conflict: fetch 0x200 (LINES=16, same idx as 0x100) -> miss, refill; then 0x100 misses again.
//  Slow memory: mem_ready low 5 cycles, gaps in mem_rvalid -> mem_req/mem_addr stable,
//   imem_miss high throughout, line correct, exactly one request.
//  Invalidate mid-refill: inv_all during beat 1 -> refill completes, next fetch 0x100 misses.
//  With ICACHE_MISS_CNT_EN: 3 misses -> miss_count=3; inv_all -> 0.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with single-line miss/refill FSM for dual-issue fetch.
// Optional miss counter output when ICACHE_MISS_CNT_EN is defined.
module icache_refill_ctrl #(
  parameter int unsigned Lines     = 16,
  parameter int unsigned LineWords = 4,
  parameter int unsigned AddrW     = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_req_i,
  input  logic [AddrW-1:0] fetch_addr_i,
  output logic [63:0]      fetch_data_o,
  output logic             fetch_valid_o,
  output logic             imem_miss_o,
  input  logic             inv_all_i,
  output logic             mem_req_o,
  output logic [AddrW-1:0] mem_addr_o,
  input  logic             mem_ready_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i
`ifdef ICACHE_MISS_CNT_EN
  ,
  output logic [31:0]      miss_count_o
`endif
);

  localparam int unsigned OffW  = $clog2(LineWords * 4);
  localparam int unsigned IdxW  = $clog2(Lines);
  localparam int unsigned TagW  = AddrW - OffW - IdxW;
  localparam int unsigned WIdxW = $clog2(LineWords);

  typedef enum logic [1:0] {StIdle, StReq, StRefill} state_e;

  state_e            state_q;
  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [31:0]       data_q [Lines][LineWords];
  logic [WIdxW-1:0]  beat_q;
  logic              inv_pend_q;
  logic              mem_req_q;
  logic [AddrW-1:0]  mem_addr_q;

  logic [IdxW-1:0]   f_idx, r_idx;
  logic [TagW-1:0]   f_tag, r_tag;
  logic [WIdxW-1:0]  w_sel, w_lo, w_hi;
  logic              hit, refill_we, last_beat;

  always_comb begin
    f_idx     = fetch_addr_i[OffW +: IdxW];
    f_tag     = fetch_addr_i[AddrW-1:OffW+IdxW];
    r_idx     = mem_addr_q[OffW +: IdxW];
    r_tag     = mem_addr_q[AddrW-1:OffW+IdxW];
    // Pairs are 8B aligned: low word is even, high word is the odd neighbour.
    w_sel     = fetch_addr_i[OffW-1:2];
    w_lo      = w_sel & ~WIdxW'(1);
    w_hi      = w_sel | WIdxW'(1);
    hit       = fetch_req_i & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
    refill_we = (state_q == StRefill) & mem_rvalid_i;
    last_beat = (beat_q == WIdxW'(LineWords - 1));
  end

  assign fetch_data_o  = {data_q[f_idx][w_hi], data_q[f_idx][w_lo]};
  assign fetch_valid_o = (state_q == StIdle) & hit;
  assign imem_miss_o   = (state_q != StIdle) | (fetch_req_i & ~hit);
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      beat_q     <= '0;
      inv_pend_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      if (inv_all_i) valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          inv_pend_q <= 1'b0;
          if (fetch_req_i && !hit) begin
            state_q    <= StReq;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {fetch_addr_i[AddrW-1:OffW], {OffW{1'b0}}};
          end
        end
        StReq: begin
          if (inv_all_i) inv_pend_q <= 1'b1;
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StRefill;
          end
        end
        StRefill: begin
          if (inv_all_i) inv_pend_q <= 1'b1;
          if (mem_rvalid_i) begin
            beat_q <= beat_q + WIdxW'(1);
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= StIdle;
              // A fence.i seen at any point of the refill leaves the line invalid.
              if (!inv_pend_q && !inv_all_i) valid_q[r_idx] <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits gate them.
  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      data_q[r_idx][beat_q] <= mem_rdata_i;
      if (last_beat) tag_q[r_idx] <= r_tag;
    end
  end

`ifdef ICACHE_MISS_CNT_EN
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q <= '0;
    end else if (inv_all_i) begin
      miss_cnt_q <= '0;
    end else if ((state_q == StIdle) && fetch_req_i && !hit && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign miss_count_o = miss_cnt_q;
`endif

`ifndef SYNTHESIS
  logic             chk_miss_q;
  logic [AddrW-1:0] chk_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_miss_q <= 1'b0;
      chk_addr_q <= '0;
    end else begin
      chk_miss_q <= imem_miss_o;
      chk_addr_q <= fetch_addr_i;
      if (chk_miss_q) begin
        assert (fetch_addr_i == chk_addr_q)
          else $error("fetch_addr changed while imem_miss was high");
      end
      if (fetch_req_i) begin
        assert (fetch_addr_i[2:0] == 3'b000) else $error("fetch_addr not 8B aligned");
      end
      assert (!(fetch_valid_o && imem_miss_o)) else $error("fetch_valid with imem_miss");
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (default 16 lines x 4 words).
// Define ICACHE_MISS_CNT_EN to also exercise the miss counter.
module tb_icache_refill_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic [63:0] fetch_data_o;
  logic        fetch_valid_o;
  logic        imem_miss_o;
  logic        inv_all_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef ICACHE_MISS_CNT_EN
  logic [31:0] miss_count_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int req_cnt  = 0;

  icache_refill_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_data_o (fetch_data_o),
    .fetch_valid_o(fetch_valid_o),
    .imem_miss_o  (imem_miss_o),
    .inv_all_i    (inv_all_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef ICACHE_MISS_CNT_EN
    ,
    .miss_count_o (miss_count_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Accepted memory requests (handshake cycles).
  always @(posedge clk_i) begin
    if (rst_ni && mem_req_o && mem_ready_i) req_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req_i  = 1'b1;
    fetch_addr_i = a;
  endtask

  // Checks a hit in the current IDLE cycle, then advances one cycle.
  task automatic check_hit(input string tag, input logic [63:0] exp);
    #1;
    check({tag, "_data"}, fetch_data_o, exp);
    check({tag, "_valid"}, {63'd0, fetch_valid_o}, 64'd1);
    check({tag, "_nomiss"}, {63'd0, imem_miss_o}, 64'd0);
    tick();
  endtask

  // Called in the miss cycle; serves one line refill with optional latency and beat gaps.
  task automatic refill(input logic [31:0] base, input logic [31:0] d0, input int ready_dly,
                        input int gap, input int inv_beat);
    int rc0;
    rc0 = req_cnt;
    #1;
    check("miss_now", {63'd0, imem_miss_o}, 64'd1);
    check("miss_no_valid", {63'd0, fetch_valid_o}, 64'd0);
    tick();
    for (int i = 0; i <= ready_dly; i++) begin
      check("req_on", {63'd0, mem_req_o}, 64'd1);
      check("req_addr", {32'd0, mem_addr_o}, {32'd0, base});
      check("req_miss", {63'd0, imem_miss_o}, 64'd1);
      if (i == ready_dly) mem_ready_i = 1'b1;
      tick();
    end
    mem_ready_i = 1'b0;
    check("req_drop", {63'd0, mem_req_o}, 64'd0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        check("gap_miss", {63'd0, imem_miss_o}, 64'd1);
        tick();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d0 + 32'(b);
      inv_all_i    = (b == inv_beat);
      tick();
      mem_rvalid_i = 1'b0;
      inv_all_i    = 1'b0;
    end
    check("one_req", 64'(req_cnt - rc0), 64'd1);
  endtask

  initial begin
    rst_ni       = 1'b0;
    fetch_req_i  = 1'b0;
    fetch_addr_i = '0;
    inv_all_i    = 1'b0;
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    #3;
    check("rst_valid", {63'd0, fetch_valid_o}, 64'd0);
    check("rst_miss", {63'd0, imem_miss_o}, 64'd0);
    check("rst_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_addr", {32'd0, mem_addr_o}, 64'd0);
`ifdef ICACHE_MISS_CNT_EN
    check("rst_cnt", {32'd0, miss_count_o}, 64'd0);
`endif
    #9 rst_ni = 1'b1;
    tick();

    // Cold miss then hit on the refilled line.
    fetch(32'h100);
    refill(32'h100, 32'hA0, 0, 0, -1);
    check_hit("cold_hit", 64'h0000_00A1_0000_00A0);
    fetch(32'h108);
    check_hit("pair_hit", 64'h0000_00A3_0000_00A2);
    check("hit_no_req", {63'd0, mem_req_o}, 64'd0);

    // Conflict on index 0 evicts 0x100.
    fetch(32'h200);
    refill(32'h200, 32'hB0, 0, 0, -1);
    check_hit("conflict_fill", 64'h0000_00B1_0000_00B0);

    // 0x100 misses again; slow memory with beat gaps.
    fetch(32'h100);
    refill(32'h100, 32'hC0, 5, 1, -1);
`ifdef ICACHE_MISS_CNT_EN
    check("cnt_three", {32'd0, miss_count_o}, 64'd3);
`endif
    check_hit("slow_fill", 64'h0000_00C1_0000_00C0);

    // Stray beat in IDLE must not corrupt the line.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0;
    check_hit("stray_beat", 64'h0000_00C1_0000_00C0);

    // fence.i during beat 1: refill completes but the line stays invalid.
    fetch(32'h140);
    refill(32'h140, 32'hD0, 0, 0, 1);
    #1;
    check("inv_refill_miss", {63'd0, imem_miss_o}, 64'd1);
    check("inv_refill_nv", {63'd0, fetch_valid_o}, 64'd0);
    refill(32'h140, 32'hD4, 0, 0, -1);
    check_hit("refetch", 64'h0000_00D5_0000_00D4);
    fetch(32'h100);
    #1;
    check("inv_clears_other", {63'd0, imem_miss_o}, 64'd1);
    refill(32'h100, 32'hC0, 0, 0, -1);
    check_hit("refill_again", 64'h0000_00C1_0000_00C0);

    // Last index (15) alongside index 0.
    fetch(32'h1F0);
    refill(32'h1F0, 32'hE0, 0, 0, -1);
    check_hit("last_idx", 64'h0000_00E1_0000_00E0);
    fetch(32'h1F8);
    check_hit("last_idx_hi", 64'h0000_00E3_0000_00E2);
    fetch(32'h108);
    check_hit("first_idx_kept", 64'h0000_00C3_0000_00C2);

    // fence.i in IDLE: same-cycle hit served, next cycle misses.
    fetch(32'h1F0);
    inv_all_i = 1'b1;
    #1;
    check("inv_same_cycle", {63'd0, fetch_valid_o}, 64'd1);
    tick();
    inv_all_i = 1'b0;
    #1;
    check("inv_idle_miss", {63'd0, imem_miss_o}, 64'd1);
    refill(32'h1F0, 32'hE0, 0, 0, -1);
    check_hit("inv_refetch", 64'h0000_00E1_0000_00E0);

`ifdef ICACHE_MISS_CNT_EN
    fetch_req_i = 1'b0;
    inv_all_i   = 1'b1;
    tick();
    inv_all_i = 1'b0;
    check("cnt_cleared", {32'd0, miss_count_o}, 64'd0);
`endif

    // Reset in the middle of a refill.
    fetch(32'h240);
    #1;
    tick();
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hF0;
    tick();
    mem_rdata_i = 32'hF1;
    tick();
    mem_rvalid_i = 1'b0;
    rst_ni       = 1'b0;
    #1;
    check("rst_mid_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_mid_nv", {63'd0, fetch_valid_o}, 64'd0);
    check("rst_mid_miss", {63'd0, imem_miss_o}, 64'd1);
    fetch_req_i = 1'b0;
    #1;
    check("rst_mid_idle", {63'd0, imem_miss_o}, 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    fetch(32'h100);
    #1;
    check("rst_invalidates", {63'd0, imem_miss_o}, 64'd1);
    check("rst_inv_nv", {63'd0, fetch_valid_o}, 64'd0);
    fetch_req_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
